// File: rtl/memory_pkg.sv
// Shared types and constants for the memory-game controller and its cursor.
package memory_pkg;

    localparam int GRID_COLS = 4;
    localparam int GRID_ROWS = 2;
    localparam int CELL_W    = 3;
    localparam int MAX_SEQ   = 8;

    typedef enum logic [5:0] {
        S_I = 6'b000001,
        S_G = 6'b000010,
        S_S = 6'b000100,
        S_P = 6'b001000,
        S_W = 6'b010000,
        S_L = 6'b100000
    } state_t;

    // Cells are numbered row-major: row * GRID_COLS + column.
    function automatic logic [CELL_W-1:0] cell_idx(input logic y, input logic [1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/memory_game_ctrl_if.sv
// Button pulses, game setup inputs and state/display outputs of the controller.
interface memory_game_if;
    logic       Start, Ack;
    logic [7:0] SS_in, INC_in;
    logic       Right, Left, Up, Down, Select;
    logic       Qi, Qg, Qs, Qp, Qw, Ql;
    logic [1:0] outX;
    logic       outY;
    logic       show_valid;
    logic [2:0] show_pos;
    logic [2:0] step;
    logic [3:0] Lives;

    modport master (
        output Start, Ack, SS_in, INC_in, Right, Left, Up, Down, Select,
        input  Qi, Qg, Qs, Qp, Qw, Ql, outX, outY, show_valid, show_pos, step, Lives
    );

    modport slave (
        input  Start, Ack, SS_in, INC_in, Right, Left, Up, Down, Select,
        output Qi, Qg, Qs, Qp, Qw, Ql, outX, outY, show_valid, show_pos, step, Lives
    );
endinterface

// File: rtl/memory_cursor.sv
// Grid cursor: wrapping X/Y registers driven by direction pulses.
module memory_cursor
    import memory_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clr,
    input  logic       en,
    input  logic       Select,
    input  logic       Right,
    input  logic       Left,
    input  logic       Up,
    input  logic       Down,
    output logic [1:0] x,
    output logic       y
);

    // Select outranks every move, so a Select cycle never moves the cursor.
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            x <= '0;
            y <= 1'b0;
        end else if (en && !Select) begin
            if (Right)          x <= x + 2'd1;
            else if (Left)      x <= x - 2'd1;
            else if (Up || Down) y <= ~y;
        end
    end

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory-game sequencer: builds the target sequence, shows it, then scores play.
module memory_game_ctrl
    import memory_pkg::*;
#(
    parameter int SEQ_LEN    = 4,
    parameter int SHOW_CYC   = 4,
    parameter int INIT_LIVES = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    memory_game_if.slave  bus
);

    localparam int CW = $clog2(SEQ_LEN * SHOW_CYC) + 1;

    state_t              state_q, state_d;
    logic [2:0]          ss_q, inc_q;
    logic [CELL_W-1:0]   pos_q [MAX_SEQ];
    logic [CW-1:0]       idx_q, sub_q;
    logic [3:0]          step_q, lives_q;
    logic [1:0]          cur_x;
    logic                cur_y;
    logic [CELL_W-1:0]   cur_cell, exp_cell;
    logic                hit, last_hit, gen_done, slot_done, show_done;
    logic                start_go;
    logic                unused_bits;

    assign unused_bits = ^{bus.SS_in[7:3], bus.INC_in[7:3], bus.INC_in[0]};

    assign start_go  = (state_q == S_I) && bus.Start;
    assign cur_cell  = cell_idx(cur_y, cur_x);
    assign exp_cell  = pos_q[step_q[2:0]];
    assign hit       = bus.Select && (cur_cell == exp_cell);
    assign last_hit  = hit && (step_q + 4'd1 == 4'(SEQ_LEN));
    // idx_q doubles as the generate counter and the shown-cell index.
    assign gen_done  = idx_q == CW'(SEQ_LEN - 1);
    assign slot_done = sub_q == CW'(SHOW_CYC - 1);
    assign show_done = gen_done && slot_done;

    memory_cursor u_cursor (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr    (start_go),
        .en     (state_q == S_P),
        .Select (bus.Select),
        .Right  (bus.Right),
        .Left   (bus.Left),
        .Up     (bus.Up),
        .Down   (bus.Down),
        .x      (cur_x),
        .y      (cur_y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_I: if (bus.Start) state_d = S_G;
            S_G: if (gen_done) state_d = S_S;
            S_S: if (show_done) state_d = S_P;
            S_P: begin
                if (last_hit)                                    state_d = S_W;
                else if (bus.Select && !hit && lives_q == 4'd1)  state_d = S_L;
            end
            S_W, S_L: if (bus.Ack) state_d = S_I;
            default: state_d = S_I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_I;
            ss_q    <= '0;
            inc_q   <= '0;
            idx_q   <= '0;
            sub_q   <= '0;
            step_q  <= '0;
            lives_q <= '0;
            for (int i = 0; i < MAX_SEQ; i++) pos_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_I: if (bus.Start) begin
                    ss_q    <= bus.SS_in[2:0];
                    inc_q   <= bus.INC_in[2:0] | 3'b001;
                    lives_q <= 4'(INIT_LIVES);
                    step_q  <= '0;
                    idx_q   <= '0;
                    sub_q   <= '0;
                end
                S_G: begin
                    // Odd increment mod 8 visits distinct cells.
                    pos_q[idx_q[2:0]] <= ss_q + idx_q[2:0] * inc_q;
                    idx_q             <= gen_done ? '0 : idx_q + 1'b1;
                end
                S_S: begin
                    if (slot_done) begin
                        sub_q <= '0;
                        idx_q <= gen_done ? '0 : idx_q + 1'b1;
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end
                S_P: if (bus.Select) begin
                    if (hit) step_q  <= step_q + 4'd1;
                    else     lives_q <= lives_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Qi         = state_q == S_I;
    assign bus.Qg         = state_q == S_G;
    assign bus.Qs         = state_q == S_S;
    assign bus.Qp         = state_q == S_P;
    assign bus.Qw         = state_q == S_W;
    assign bus.Ql         = state_q == S_L;
    assign bus.outX       = cur_x;
    assign bus.outY       = cur_y;
    assign bus.show_valid = state_q == S_S;
    assign bus.show_pos   = (state_q == S_S) ? pos_q[idx_q[2:0]] : '0;
    assign bus.step       = step_q[2:0];
    assign bus.Lives      = lives_q;

endmodule
